// File: rtl/hardnet_cfg_loader_pkg.sv
// Shared definitions for the hardnet configuration loader.
// Holds the FSM state encodings, header field positions, the latched
// header payload type and a header legality helper.
package hardnet_cfg_loader_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 16;
    localparam int unsigned DATA_WIDTH     = 32;

    // FSM state encodings
    localparam logic [2:0] CFG_IDLE   = 3'd0;
    localparam logic [2:0] CFG_HDR_RD = 3'd1;
    localparam logic [2:0] CFG_HDR_WT = 3'd2;
    localparam logic [2:0] CFG_WB_RD  = 3'd3;
    localparam logic [2:0] CFG_WB_WT  = 3'd4;
    localparam logic [2:0] CFG_DONE   = 3'd5;
    localparam logic [2:0] CFG_ERR    = 3'd6;

    // Layer header word: {neuron count, weights per neuron}
    localparam int unsigned HDR_N_MSB = 31;
    localparam int unsigned HDR_N_LSB = 16;
    localparam int unsigned HDR_W_MSB = 15;
    localparam int unsigned HDR_W_LSB = 0;

    typedef struct packed {
        logic [15:0] n;
        logic [15:0] w;
    } hdr_t;

    // A header is unusable when either count is zero or beyond the array size
    function automatic logic hdr_bad(input hdr_t h, input int unsigned max_n,
                                     input int unsigned max_w);
        return (h.n == 16'd0) || (32'(h.n) > max_n) ||
               (h.w == 16'd0) || (32'(h.w) > max_w);
    endfunction

endpackage

// File: rtl/hardnet_cfg_loader_if.sv
// Word-memory read port used by the configuration loader.
// master: loader side (issues mem_rd_en/mem_addr, receives mem_rdata/mem_rvalid)
// slave : memory side
interface hardnet_cfg_loader_if
    import hardnet_cfg_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rvalid;

    modport master (output mem_rd_en, output mem_addr,
                    input  mem_rdata, input  mem_rvalid);
    modport slave  (input  mem_rd_en, input  mem_addr,
                    output mem_rdata, output mem_rvalid);
endinterface

// File: rtl/hardnet_cfg_loader.sv
// Boot-time sequencer streaming per-layer weight/bias tables from word memory
// into the hardnet layer array. One read outstanding at most.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   start, base_addr        : load request pulse and layer-1 header address
//   mem (master)            : memory read port (rd_en/addr out, rdata/rvalid in)
//   configlayer/configneuron: layer (1-based) / neuron (0-based) of current word
//   weight_Value/weight_valid, bias_Value/bias_valid : word strobes
//   cfg_busy/cfg_done/cfg_error : load status levels
module hardnet_cfg_loader
    import hardnet_cfg_loader_pkg::*;
#(
    parameter int unsigned NUM_LAYERS  = 4,
    parameter int unsigned MAX_NEURONS = 30,
    parameter int unsigned MAX_WEIGHTS = 784,
    parameter int unsigned ADDR_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    hardnet_cfg_loader_if.master    mem,
    output logic [31:0]             configlayer,
    output logic [31:0]             configneuron,
    output logic [31:0]             weight_Value,
    output logic                    weight_valid,
    output logic [31:0]             bias_Value,
    output logic                    bias_valid,
    output logic                    cfg_busy,
    output logic                    cfg_done,
    output logic                    cfg_error
);

    logic [2:0]            state_q,      state_d;
    logic [ADDR_WIDTH-1:0] ptr_q,        ptr_d;
    logic [7:0]            layer_q,      layer_d;
    logic [15:0]           neuron_q,     neuron_d;
    logic [15:0]           widx_q,       widx_d;
    hdr_t                  hdr_q,        hdr_d;
    logic                  rd_en_q,      rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [7:0]            cfg_layer_q,  cfg_layer_d;
    logic [15:0]           cfg_neuron_q, cfg_neuron_d;
    logic [31:0]           wval_q,       wval_d;
    logic                  wvalid_q,     wvalid_d;
    logic [31:0]           bval_q,       bval_d;
    logic                  bvalid_q,     bvalid_d;
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;
    logic                  error_q,      error_d;
    hdr_t                  hdr_in;

    assign hdr_in = '{n: mem.mem_rdata[HDR_N_MSB:HDR_N_LSB],
                      w: mem.mem_rdata[HDR_W_MSB:HDR_W_LSB]};

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= CFG_IDLE;
            ptr_q        <= '0;
            layer_q      <= '0;
            neuron_q     <= '0;
            widx_q       <= '0;
            hdr_q        <= '0;
            rd_en_q      <= 1'b0;
            addr_q       <= '0;
            cfg_layer_q  <= '0;
            cfg_neuron_q <= '0;
            wval_q       <= '0;
            wvalid_q     <= 1'b0;
            bval_q       <= '0;
            bvalid_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            layer_q      <= layer_d;
            neuron_q     <= neuron_d;
            widx_q       <= widx_d;
            hdr_q        <= hdr_d;
            rd_en_q      <= rd_en_d;
            addr_q       <= addr_d;
            cfg_layer_q  <= cfg_layer_d;
            cfg_neuron_q <= cfg_neuron_d;
            wval_q       <= wval_d;
            wvalid_q     <= wvalid_d;
            bval_q       <= bval_d;
            bvalid_q     <= bvalid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next-state and next-output logic. A read request is registered on the
    // transition into a *_RD state, so mem_rd_en is high exactly for that state.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        layer_d      = layer_q;
        neuron_d     = neuron_q;
        widx_d       = widx_q;
        hdr_d        = hdr_q;
        rd_en_d      = 1'b0;
        addr_d       = addr_q;
        cfg_layer_d  = cfg_layer_q;
        cfg_neuron_d = cfg_neuron_q;
        wval_d       = wval_q;
        wvalid_d     = 1'b0;
        bval_d       = bval_q;
        bvalid_d     = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            CFG_IDLE, CFG_DONE, CFG_ERR: begin
                // DONE is entered with the last bias strobe; status follows a cycle later
                if (state_q == CFG_DONE) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                if (start && !busy_q) begin
                    ptr_d        = base_addr;
                    layer_d      = 8'd1;
                    neuron_d     = 16'd0;
                    widx_d       = 16'd0;
                    cfg_layer_d  = 8'd1;
                    cfg_neuron_d = 16'd0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    rd_en_d      = 1'b1;
                    addr_d       = base_addr;
                    state_d      = CFG_HDR_RD;
                end
            end
            CFG_HDR_RD: begin
                ptr_d   = ptr_q + ADDR_WIDTH'(1);
                state_d = CFG_HDR_WT;
            end
            CFG_HDR_WT: begin
                if (mem.mem_rvalid) begin
                    hdr_d = hdr_in;
                    if (hdr_bad(hdr_in, MAX_NEURONS, MAX_WEIGHTS)) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = CFG_ERR;
                    end else begin
                        rd_en_d = 1'b1;
                        addr_d  = ptr_q;
                        state_d = CFG_WB_RD;
                    end
                end
            end
            CFG_WB_RD: begin
                ptr_d   = ptr_q + ADDR_WIDTH'(1);
                state_d = CFG_WB_WT;
            end
            CFG_WB_WT: begin
                if (mem.mem_rvalid) begin
                    // Tag the outgoing word with the counters it belongs to;
                    // the tags move only together with a new strobe
                    cfg_layer_d  = layer_q;
                    cfg_neuron_d = neuron_q;
                    rd_en_d      = 1'b1;
                    addr_d       = ptr_q;
                    state_d      = CFG_WB_RD;
                    if (widx_q < hdr_q.w) begin
                        wval_d   = mem.mem_rdata;
                        wvalid_d = 1'b1;
                        widx_d   = widx_q + 16'd1;
                    end else begin
                        bval_d   = mem.mem_rdata;
                        bvalid_d = 1'b1;
                        widx_d   = 16'd0;
                        if (neuron_q == hdr_q.n - 16'd1) begin
                            neuron_d = 16'd0;
                            layer_d  = layer_q + 8'd1;
                            if (layer_q >= 8'(NUM_LAYERS)) begin
                                rd_en_d = 1'b0;
                                state_d = CFG_DONE;
                            end else begin
                                state_d = CFG_HDR_RD;
                            end
                        end else begin
                            neuron_d = neuron_q + 16'd1;
                        end
                    end
                end
            end
            default: state_d = CFG_IDLE;
        endcase
    end

    assign mem.mem_rd_en = rd_en_q;
    assign mem.mem_addr  = addr_q;
    assign configlayer   = {24'd0, cfg_layer_q};
    assign configneuron  = {16'd0, cfg_neuron_q};
    assign weight_Value  = wval_q;
    assign weight_valid  = wvalid_q;
    assign bias_Value    = bval_q;
    assign bias_valid    = bvalid_q;
    assign cfg_busy      = busy_q;
    assign cfg_done      = done_q;
    assign cfg_error     = error_q;

endmodule
